// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: hunts word alignment on control-token runs, then decodes DE/control/pixel byte.
// Latency 1 cycle word_i -> outputs; no backpressure, one word accepted every clock.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN      = 16,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_SETTLE    = 4,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] word_i,
    output logic       bitslip_o,
    output logic       aligned_o,
    output logic [3:0] slip_count_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int TMR_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(TOKEN_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [TMR_W-1:0]  timer;
    logic [SET_W-1:0]  settle;
    logic [LOSS_W-1:0] loss;

    logic       is_token;
    logic [1:0] token_val;
    logic [7:0] q;
    logic [7:0] dec;

    always_comb begin
        is_token  = 1'b1;
        token_val = 2'b00;
        case (word_i)
            10'b1101010100: token_val = 2'b00;
            10'b0010101011: token_val = 2'b01;
            10'b0101010100: token_val = 2'b10;
            10'b1010101011: token_val = 2'b11;
            default:        is_token  = 1'b0;
        endcase

        // word[9] flags inversion, word[8] selects XOR vs XNOR chaining
        q      = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        dec    = 8'd0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = word_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= SEARCH;
            run          <= '0;
            timer        <= '0;
            settle       <= '0;
            loss         <= '0;
            bitslip_o    <= 1'b0;
            aligned_o    <= 1'b0;
            slip_count_o <= 4'd0;
            de_o         <= 1'b0;
            ctrl_o       <= 2'b00;
            data_o       <= 8'd0;
        end else begin
            bitslip_o <= 1'b0;
            case (state)
                SEARCH: begin
                    de_o   <= 1'b0;
                    ctrl_o <= 2'b00;
                    data_o <= 8'd0;
                    // Completing the run takes priority over a coincident timeout
                    if (is_token && run == RUN_LAST) begin
                        state        <= LOCKED;
                        aligned_o    <= 1'b1;
                        run          <= '0;
                        timer        <= '0;
                        loss         <= '0;
                        slip_count_o <= 4'd0;
                    end else begin
                        if (is_token)
                            run <= (run == RUN_MAX) ? run : run + 1'b1;
                        else
                            run <= '0;
                        if (timer == TMR_LAST) begin
                            state        <= SLIP_WAIT;
                            bitslip_o    <= 1'b1;
                            slip_count_o <= (slip_count_o == 4'd9) ? 4'd0 : slip_count_o + 4'd1;
                            timer        <= '0;
                            settle       <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end

                SLIP_WAIT: begin
                    if (settle == SET_LAST) begin
                        state <= SEARCH;
                        run   <= '0;
                        timer <= '0;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end

                LOCKED: begin
                    if (is_token) begin
                        loss   <= '0;
                        de_o   <= 1'b0;
                        ctrl_o <= token_val;
                        data_o <= 8'd0;
                    end else if (loss == LOSS_LAST) begin
                        state        <= SEARCH;
                        aligned_o    <= 1'b0;
                        slip_count_o <= 4'd0;
                        run          <= '0;
                        timer        <= '0;
                        loss         <= '0;
                        de_o         <= 1'b0;
                        ctrl_o       <= 2'b00;
                        data_o       <= 8'd0;
                    end else begin
                        loss   <= loss + 1'b1;
                        de_o   <= 1'b1;
                        data_o <= dec;
                    end
                end

                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: alignment hunt, decode, lock loss and reset behaviour.
module tb_tmds_channel_decoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] D03 = 10'b0100000001;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] word_i = 10'd0;
    logic       bitslip_o;
    logic       aligned_o;
    logic [3:0] slip_count_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic [7:0] data_o;

    int tests = 0;
    int fails = 0;

    tmds_channel_decoder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .word_i       (word_i),
        .bitslip_o    (bitslip_o),
        .aligned_o    (aligned_o),
        .slip_count_o (slip_count_o),
        .de_o         (de_o),
        .ctrl_o       (ctrl_o),
        .data_o       (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive at a falling edge; on return the registered result of w is visible.
    task automatic put(input logic [9:0] w);
        word_i = w;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        word_i = 10'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        word_i = T00;
        @(negedge clk_i);
        @(negedge clk_i);
        tests++;
        if ({bitslip_o, aligned_o, slip_count_o, de_o, ctrl_o, data_o} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b expected all zero",
                     {bitslip_o, aligned_o, slip_count_o, de_o, ctrl_o, data_o});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_align();
        int slips_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            put(T00);
            if (bitslip_o) slips_seen++;
            if (i == 15) begin
                tests++;
                if (aligned_o !== 1'b0 || de_o !== 1'b0) begin
                    fails++;
                    $display("FAIL align_early aligned=%b de=%b expected 0 0", aligned_o, de_o);
                end
            end
            if (i == 16) begin
                tests++;
                if (aligned_o !== 1'b1) begin
                    fails++;
                    $display("FAIL align_at_16 aligned=%b expected 1", aligned_o);
                end
            end
        end
        tests++;
        if (slips_seen != 0 || de_o !== 1'b0 || ctrl_o !== 2'b00) begin
            fails++;
            $display("FAIL align_tokens slips=%0d de=%b ctrl=%b expected 0 0 00", slips_seen, de_o, ctrl_o);
        end
    endtask

    task automatic test_decode();
        put(10'b0100000000);
        tests++;
        if (de_o !== 1'b1 || data_o !== 8'h00) begin
            fails++;
            $display("FAIL decode_00 de=%b data=%h expected 1 00", de_o, data_o);
        end
        put(10'b1011111111);
        tests++;
        if (de_o !== 1'b1 || data_o !== 8'hFE || ctrl_o !== 2'b00) begin
            fails++;
            $display("FAIL decode_fe de=%b data=%h ctrl=%b expected 1 fe 00", de_o, data_o, ctrl_o);
        end
        put(10'b0001010101);
        tests++;
        if (data_o !== 8'h01) begin
            fails++;
            $display("FAIL decode_xnor data=%h expected 01", data_o);
        end
        put(D03);
        tests++;
        if (data_o !== 8'h03) begin
            fails++;
            $display("FAIL decode_xor data=%h expected 03", data_o);
        end
    endtask

    task automatic test_ctrl_hold();
        put(T10);
        tests++;
        if (de_o !== 1'b0 || ctrl_o !== 2'b10 || data_o !== 8'h00) begin
            fails++;
            $display("FAIL ctrl_token de=%b ctrl=%b data=%h expected 0 10 00", de_o, ctrl_o, data_o);
        end
        put(D03);
        put(10'b0100000000);
        tests++;
        if (de_o !== 1'b1 || ctrl_o !== 2'b10) begin
            fails++;
            $display("FAIL ctrl_hold de=%b ctrl=%b expected 1 10", de_o, ctrl_o);
        end
        put(T11);
        tests++;
        if (ctrl_o !== 2'b11) begin
            fails++;
            $display("FAIL ctrl_11 ctrl=%b expected 11", ctrl_o);
        end
        put(T01);
        tests++;
        if (ctrl_o !== 2'b01 || aligned_o !== 1'b1) begin
            fails++;
            $display("FAIL ctrl_01 ctrl=%b aligned=%b expected 01 1", ctrl_o, aligned_o);
        end
    endtask

    task automatic test_run_restart();
        do_reset();
        for (int i = 0; i < 15; i++) put(T00);
        put(D03);
        for (int i = 0; i < 15; i++) put(T00);
        tests++;
        if (aligned_o !== 1'b0) begin
            fails++;
            $display("FAIL run_restart_early aligned=%b expected 0", aligned_o);
        end
        put(T00);
        tests++;
        if (aligned_o !== 1'b1) begin
            fails++;
            $display("FAIL run_restart_lock aligned=%b expected 1", aligned_o);
        end
    endtask

    task automatic test_loss();
        for (int i = 0; i < 4095; i++) put(D03);
        tests++;
        if (aligned_o !== 1'b1 || de_o !== 1'b1 || data_o !== 8'h03) begin
            fails++;
            $display("FAIL loss_early aligned=%b de=%b data=%h expected 1 1 03", aligned_o, de_o, data_o);
        end
        put(D03);
        tests++;
        if (aligned_o !== 1'b0 || de_o !== 1'b0 || data_o !== 8'h00 || slip_count_o !== 4'd0) begin
            fails++;
            $display("FAIL loss_drop aligned=%b de=%b data=%h slips=%0d expected 0 0 00 0",
                     aligned_o, de_o, data_o, slip_count_o);
        end
        // back in SEARCH: a fresh token run relocks without any slip
        for (int i = 0; i < 16; i++) put(T00);
        tests++;
        if (aligned_o !== 1'b1) begin
            fails++;
            $display("FAIL loss_relock aligned=%b expected 1", aligned_o);
        end
    endtask

    task automatic test_bitslip_hunt();
        logic [19:0] dbl;
        logic [9:0]  w;
        int offset = 3;
        int slips = 0;
        int last_slip = 0;
        int lock_cycle = 0;
        int bad_space = 0;
        int bad_count = 0;
        int first_slip = 0;
        logic prev_slip = 1'b0;
        int double_pulse = 0;
        do_reset();
        dbl = {T00, T00};
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            w = 10'(dbl >> offset);
            put(w);
            if (bitslip_o && prev_slip) double_pulse++;
            prev_slip = bitslip_o;
            if (bitslip_o) begin
                slips++;
                if (slips == 1) first_slip = cyc;
                else if (cyc - last_slip != 2052) bad_space++;
                if (slip_count_o !== 4'(slips % 10)) bad_count++;
                last_slip = cyc;
                offset = (offset + 1) % 10;
            end
            if (aligned_o) begin
                lock_cycle = cyc;
                break;
            end
        end
        tests++;
        if (lock_cycle != 14380) begin
            fails++;
            $display("FAIL hunt_lock_cycle got %0d expected 14380", lock_cycle);
        end
        tests++;
        if (slips != 7 || first_slip != 2048) begin
            fails++;
            $display("FAIL hunt_slips got %0d first at %0d expected 7 first at 2048", slips, first_slip);
        end
        tests++;
        if (bad_space != 0 || double_pulse != 0) begin
            fails++;
            $display("FAIL hunt_spacing bad_gaps=%0d double_pulses=%0d expected 0 0", bad_space, double_pulse);
        end
        tests++;
        if (bad_count != 0 || slip_count_o !== 4'd0) begin
            fails++;
            $display("FAIL hunt_slip_count bad=%0d after_lock=%0d expected 0 0", bad_count, slip_count_o);
        end
    endtask

    task automatic test_reset_mid_slip();
        int guard = 0;
        int slips_seen = 0;
        do_reset();
        while (bitslip_o !== 1'b1 && guard < 3000) begin
            put(D03);
            guard++;
        end
        tests++;
        if (guard != 2048 || slip_count_o !== 4'd1) begin
            fails++;
            $display("FAIL midreset_setup slip_after=%0d count=%0d expected 2048 1", guard, slip_count_o);
        end
        rst_i = 1'b1;
        #1;
        tests++;
        if ({bitslip_o, aligned_o, slip_count_o, de_o, ctrl_o, data_o} !== 17'd0) begin
            fails++;
            $display("FAIL midreset_outputs got %b expected all zero",
                     {bitslip_o, aligned_o, slip_count_o, de_o, ctrl_o, data_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put(T00);
            if (bitslip_o) slips_seen++;
        end
        tests++;
        if (aligned_o !== 1'b1 || slips_seen != 0) begin
            fails++;
            $display("FAIL midreset_relock aligned=%b slips=%0d expected 1 0", aligned_o, slips_seen);
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_decode();
        test_ctrl_hold();
        test_run_restart();
        test_loss();
        test_bitslip_hunt();
        test_reset_mid_slip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
